// File: rtl/serializer.sv
// serializer: sends a captured cache line as NUM_WORDS beats (word 0 first) with per-beat byte addresses.
//   clk, rst_n (async, active-low)  | line_in, addr_in, start : line capture request (sampled in IDLE)
//   word_out, word_addr, word_valid, word_last, word_ready : beat handshake | busy, done : status
module serializer #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WORD_W*NUM_WORDS-1:0] line_in,
  input  logic [31:0]                 addr_in,
  input  logic                        start,
  output logic                        busy,
  output logic [WORD_W-1:0]           word_out,
  output logic [31:0]                 word_addr,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic                        word_last,
  output logic                        done
);
  localparam int LINE_W = WORD_W * NUM_WORDS;
  localparam int IDX_W  = $clog2(NUM_WORDS);
  localparam int BYTE_W = $clog2(WORD_W / 8);
  localparam int OFF_W  = IDX_W + BYTE_W;
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t              r_state, w_next;
  logic [LINE_W-1:0]   r_shift;
  logic [31-OFF_W:0]   r_addr;
  logic [IDX_W-1:0]    r_idx;
  logic                w_capture, w_xfer;
  assign w_capture = (r_state == IDLE) && start;
  assign w_xfer    = word_valid && word_ready;
  assign word_out  = r_shift[WORD_W-1:0];
  // the beat index fills the in-line offset bits, so it can never carry into the captured line address
  assign word_addr = {r_addr, r_idx, {BYTE_W{1'b0}}};
  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    word_valid = 1'b0;
    word_last  = 1'b0;
    done       = 1'b0;
    case (r_state)
      IDLE: w_next = start ? SEND : IDLE;
      SEND: begin
        busy       = 1'b1;
        word_valid = 1'b1;
        word_last  = r_idx == IDX_W'(NUM_WORDS - 1);
        w_next     = (word_ready && word_last) ? DONE : SEND;
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_shift <= '0;
      r_addr  <= '0;
      r_idx   <= '0;
    end else if (w_capture) begin
      r_shift <= line_in;
      r_addr  <= addr_in[31:OFF_W];
      r_idx   <= '0;
    end else if (w_xfer) begin
      r_shift <= r_shift >> WORD_W;
      r_idx   <= r_idx + IDX_W'(1);
    end
endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 Parameter WORD_W, default 32, width of one output beat in bits.
REQ-002 Parameter NUM_WORDS, default 8, beats per line; line width = WORD_W*NUM_WORDS (256 at defaults).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 line_in  input  256  cache line to send; word k = line_in[32k+31:32k].
REQ-006 addr_in  input  32  byte address of the line; bits [4:0] ignored.
REQ-007 start  input  1  request to send line_in/addr_in; sampled only in IDLE.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 word_out  output  32  current beat data.
REQ-010 word_addr  output  32  byte address of the current beat.
REQ-011 word_valid  output  1  beat offered to the downstream (memory) side.
REQ-012 word_ready  input  1  downstream accepts the beat this cycle.
REQ-013 word_last  output  1  current beat is word 7.
REQ-014 done  output  1  one-cycle pulse after the final beat transfers.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SEND, DONE.
REQ-016 In IDLE with start=1, the block SHALL capture line_in into a 256-bit shift register, capture addr_in[31:5], clear the beat index to 0, and enter SEND on the next edge.
REQ-017 start SHALL be ignored in SEND and DONE; the captured line and address SHALL NOT change until the next IDLE capture.
REQ-018 word_valid SHALL be 1 in SEND and 0 in IDLE and DONE.
REQ-019 A beat transfers on any edge where word_valid=1 and word_ready=1.
REQ-020 Beats SHALL be sent in ascending order, word 0 (line bits [31:0]) first and word 7 (bits [255:224]) last, matching the receive-side packing.
REQ-021 word_out SHALL equal the low 32 bits of the shift register; on each transfer the register SHALL shift right by 32 and the index SHALL increment by 1.
REQ-022 word_addr SHALL equal {captured addr[31:5], index[2:0], 2'b00}; no carry out of bit 4 is possible.
REQ-023 word_last SHALL be 1 only when in SEND and the index equals 7.
REQ-024 While word_valid=1 and word_ready=0, word_out, word_addr, word_last and the index SHALL hold unchanged (no beat dropped or duplicated).
REQ-025 A transfer with word_last=1 SHALL move the FSM to DONE; DONE SHALL assert done for exactly one cycle and return to IDLE on the next edge.
REQ-026 busy SHALL be 1 in SEND and DONE.
REQ-027 Latency: with word_ready held at 1, start sampled on edge N gives the first beat on edges N+1..N+8, done high in the cycle after edge N+8, IDLE after edge N+9, and the earliest next capture on edge N+10.
REQ-028 word_ready asserted while word_valid=0 SHALL have no effect.

Reset
REQ-029 On rst_n=0, the block SHALL immediately, without waiting for clk, enter IDLE and clear the shift register, captured address, index, word_valid, word_last, done and busy to 0.
REQ-030 Reset asserted mid-transfer SHALL abandon the line; after release no further beats SHALL be emitted until a new start is seen.
REQ-031 The first edge after rst_n rises SHALL be able to accept start.

Verification
REQ-032 Line words k=0..7 = 32'hA0000000+k, addr_in=32'h0000_1234, word_ready=1 -> beats A0000000..A0000007 at addresses 0x1220,0x1224,...,0x123C; word_last on the 8th beat only; one done pulse.
REQ-033 Same line, word_ready toggling 1,0,1,0,... -> identical 8-beat sequence, each beat held stable while stalled, done after the 8th accepted beat.
REQ-034 start pulsed again at beats 3 and 6 with a different line -> ignored; original 8 words sent unchanged; second line is sent only if start is re-asserted in IDLE.
REQ-035 rst_n driven low between clk edges after 4 beats -> word_valid, busy, done fall to 0 immediately; no beats after release; a new start sends a full 8 beats from word 0.
REQ-036 Back-to-back: start held at 1 continuously with word_ready=1 -> captures on edges N and N+10, 16 beats total, two done pulses 10 cycles apart.
REQ-037 addr_in=32'hFFFF_FFFF -> word_addr runs 0xFFFFFFE0..0xFFFFFFFC with no wrap into bits [31:5].
